pc_watch_unit: RTL and testbench

Synthesizable program-counter watchpoint unit for the single-cycle RISC-V core. It sits beside the datapath, sampling `PC`/`PCNext` on every retired instruction. It counts matches on a configurable number of independent watch channels and raises a sticky halt request when a channel reaches its programmed limit. This moves the "stop after N loop iterations" check from bench code into reusable, parametrised RTL with multiple channels and two match modes.

---
 rtl/pc_watch_pkg.sv | 17 +
 rtl/pc_watch_chan.sv | 74 +++++++
 rtl/pc_watch_unit.sv | 79 +++++++
 tb/tb_pc_watch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_watch_pkg.sv
// rtl/pc_watch_pkg.sv - shared types and defaults for the PC watchpoint unit
package pc_watch_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic {
        MODE_PC   = 1'b0,
        MODE_EDGE = 1'b1
    } watch_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } chan_state_t;

endpackage

// File: rtl/pc_watch_chan.sv
// rtl/pc_watch_chan.sv - one watch channel: config, comparator, saturating counter, FSM
module pc_watch_chan
    import pc_watch_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  pc_next,
    input  logic             cfg_sel,
    input  logic             cfg_en,
    input  logic             cfg_mode,
    input  logic [XLEN-1:0]  cfg_from,
    input  logic [XLEN-1:0]  cfg_to,
    input  logic [CNT_W-1:0] cfg_limit,
    output logic             hit,
    output logic [CNT_W-1:0] count,
    output logic             halt_cond
);

    chan_state_t      state_q, state_d;
    watch_mode_t      mode_q;
    logic [XLEN-1:0]  from_q;
    logic [XLEN-1:0]  to_q;
    logic [CNT_W-1:0] limit_q;
    logic             match;
    logic             at_limit;

    // A config write to this channel in the same cycle suppresses the match.
    always_comb begin
        match    = retire && (state_q != IDLE) && (pc == from_q) &&
                   ((mode_q == MODE_PC) || (pc_next == to_q)) && !cfg_sel;
        at_limit = (limit_q != '0) &&
                   (({1'b0, count} + (CNT_W+1)'(1)) == {1'b0, limit_q});
        halt_cond = match && (state_q == ARMED) && at_limit;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_sel) begin
            state_d = cfg_en ? ARMED : IDLE;
        end else if (halt_cond) begin
            state_d = FIRED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_PC;
            from_q  <= '0;
            to_q    <= '0;
            limit_q <= '0;
            count   <= '0;
            hit     <= 1'b0;
        end else begin
            state_q <= state_d;
            hit     <= match;
            if (cfg_sel) begin
                mode_q  <= watch_mode_t'(cfg_mode);
                from_q  <= cfg_from;
                to_q    <= cfg_to;
                limit_q <= cfg_limit;
                count   <= '0;
            end else if (match && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_watch_unit.sv
// rtl/pc_watch_unit.sv - multi-channel PC watchpoint unit with sticky halt request
module pc_watch_unit
    import pc_watch_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int NUM_WATCH = 4,
    parameter int CNT_W     = 8,
    localparam int IDX_W    = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       retire,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            pc_next,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic                       cfg_en,
    input  logic                       cfg_mode,
    input  logic [XLEN-1:0]            cfg_from,
    input  logic [XLEN-1:0]            cfg_to,
    input  logic [CNT_W-1:0]           cfg_limit,
    input  logic                       halt_clr,
    output logic [NUM_WATCH-1:0]       hit,
    output logic [NUM_WATCH*CNT_W-1:0] count,
    output logic                       halt_req,
    output logic [IDX_W-1:0]           halt_idx
);

    logic [NUM_WATCH-1:0] halt_cond;
    logic                 any_halt;
    logic [IDX_W-1:0]     halt_enc;

    for (genvar g = 0; g < NUM_WATCH; g++) begin : g_chan
        pc_watch_chan #(
            .XLEN  (XLEN),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .retire    (retire),
            .pc        (pc),
            .pc_next   (pc_next),
            .cfg_sel   (cfg_we && (cfg_idx == IDX_W'(g))),
            .cfg_en    (cfg_en),
            .cfg_mode  (cfg_mode),
            .cfg_from  (cfg_from),
            .cfg_to    (cfg_to),
            .cfg_limit (cfg_limit),
            .hit       (hit[g]),
            .count     (count[g*CNT_W +: CNT_W]),
            .halt_cond (halt_cond[g])
        );
    end

    // Lowest-numbered halting channel wins.
    always_comb begin
        any_halt = |halt_cond;
        halt_enc = '0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            if (halt_cond[i]) begin
                halt_enc = IDX_W'(i);
            end
        end
    end

    // A pending halt freezes its index unless cleared in the same cycle as a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_req <= 1'b0;
            halt_idx <= '0;
        end else if (any_halt && (!halt_req || halt_clr)) begin
            halt_req <= 1'b1;
            halt_idx <= halt_enc;
        end else if (halt_clr) begin
            halt_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_watch_unit.sv
// tb/tb_pc_watch_unit.sv - directed self-checking bench for pc_watch_unit
module tb_pc_watch_unit;

    logic        clk;
    logic        rst_n;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic        cfg_mode;
    logic [31:0] cfg_from;
    logic [31:0] cfg_to;
    logic [7:0]  cfg_limit;
    logic        halt_clr;
    logic [3:0]  hit;
    logic [31:0] count;
    logic        halt_req;
    logic [1:0]  halt_idx;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    pc_watch_unit #(
        .XLEN      (32),
        .NUM_WATCH (4),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .retire    (retire),
        .pc        (pc),
        .pc_next   (pc_next),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_en    (cfg_en),
        .cfg_mode  (cfg_mode),
        .cfg_from  (cfg_from),
        .cfg_to    (cfg_to),
        .cfg_limit (cfg_limit),
        .halt_clr  (halt_clr),
        .hit       (hit),
        .count     (count),
        .halt_req  (halt_req),
        .halt_idx  (halt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cnt(input int i);
        return count[i*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic en, input logic mode,
                       input logic [31:0] from, input logic [31:0] to, input logic [7:0] limit);
        cfg_idx   = idx;
        cfg_en    = en;
        cfg_mode  = mode;
        cfg_from  = from;
        cfg_to    = to;
        cfg_limit = limit;
        cfg_we    = 1'b1;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic ret(input logic [31:0] a, input logic [31:0] b, input logic clr);
        retire   = 1'b1;
        pc       = a;
        pc_next  = b;
        halt_clr = clr;
        step();
        retire   = 1'b0;
        halt_clr = 1'b0;
    endtask

    task automatic loop_iter();
        ret(32'h1000, 32'h1004, 1'b0);
        ret(32'h1004, 32'h1008, 1'b0);
        ret(32'h1008, 32'h100C, 1'b0);
        ret(32'h100C, 32'h1000, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; retire = 1'b0; pc = '0; pc_next = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_mode = 1'b0;
        cfg_from = '0; cfg_to = '0; cfg_limit = '0; halt_clr = 1'b0;
        step();
        step();
        chk("reset_hit", 32'(hit), 32'h0);
        chk("reset_count", count, 32'h0);
        chk("reset_halt_req", 32'(halt_req), 32'h0);
        chk("reset_halt_idx", 32'(halt_idx), 32'h0);
        rst_n = 1'b1;
        step();

        // Loop edge with limit 10 on ch0, count-only PC watch on ch1
        cfg(2'd0, 1'b1, 1'b1, 32'h100C, 32'h1000, 8'd10);
        cfg(2'd1, 1'b1, 1'b0, 32'h1004, 32'h0, 8'd0);
        for (int i = 0; i < 9; i++) loop_iter();
        chk("loop9_count0", 32'(cnt(0)), 32'd9);
        chk("loop9_count1", 32'(cnt(1)), 32'd9);
        chk("loop9_halt_req", 32'(halt_req), 32'h0);
        loop_iter();
        chk("loop10_halt_req", 32'(halt_req), 32'h1);
        chk("loop10_halt_idx", 32'(halt_idx), 32'h0);
        chk("loop10_count0", 32'(cnt(0)), 32'd10);
        chk("loop10_hit", 32'(hit), 32'h1);
        step();
        chk("hit_pulse_drop", 32'(hit), 32'h0);
        halt_clr = 1'b1;
        step();
        halt_clr = 1'b0;
        chk("clr_halt_req", 32'(halt_req), 32'h0);

        // Saturation; ch0 in FIRED must not re-fire, ch1 limit 0 never halts
        for (int i = 0; i < 290; i++) loop_iter();
        chk("sat_count0", 32'(cnt(0)), 32'd255);
        chk("sat_count1", 32'(cnt(1)), 32'd255);
        chk("sat_halt_req", 32'(halt_req), 32'h0);

        // Simultaneous halts on ch2 (PC) and ch3 (edge)
        cfg(2'd2, 1'b1, 1'b0, 32'h1008, 32'h0, 8'd3);
        cfg(2'd3, 1'b1, 1'b1, 32'h1008, 32'h100C, 8'd3);
        loop_iter();
        loop_iter();
        chk("sim_count2_pre", 32'(cnt(2)), 32'd2);
        chk("sim_count3_pre", 32'(cnt(3)), 32'd2);
        chk("sim_halt_pre", 32'(halt_req), 32'h0);
        ret(32'h1000, 32'h1004, 1'b0);
        ret(32'h1004, 32'h1008, 1'b0);
        ret(32'h1008, 32'h100C, 1'b0);
        chk("sim_halt_req", 32'(halt_req), 32'h1);
        chk("sim_halt_idx", 32'(halt_idx), 32'd2);
        chk("sim_hit", 32'(hit), 32'hC);
        chk("sim_count3", 32'(cnt(3)), 32'd3);
        ret(32'h100C, 32'h1000, 1'b0);

        // Pending halt freezes index; clear/set collision takes the new channel
        cfg(2'd0, 1'b1, 1'b0, 32'h1000, 32'h0, 8'd2);
        cfg(2'd1, 1'b1, 1'b0, 32'h1004, 32'h0, 8'd1);
        chk("recfg_count0", 32'(cnt(0)), 32'd0);
        ret(32'h1000, 32'h1004, 1'b0);
        chk("col_count0", 32'(cnt(0)), 32'd1);
        ret(32'h1004, 32'h1008, 1'b0);
        chk("frozen_count1", 32'(cnt(1)), 32'd1);
        chk("frozen_halt_idx", 32'(halt_idx), 32'd2);
        ret(32'h1000, 32'h1004, 1'b1);
        chk("col_halt_req", 32'(halt_req), 32'h1);
        chk("col_halt_idx", 32'(halt_idx), 32'd0);
        chk("col_count0_lim", 32'(cnt(0)), 32'd2);
        halt_clr = 1'b1;
        step();
        halt_clr = 1'b0;
        chk("clr2_halt_req", 32'(halt_req), 32'h0);

        // Config write and match on ch0 in the same cycle
        cfg_idx = 2'd0; cfg_en = 1'b1; cfg_mode = 1'b0;
        cfg_from = 32'h1000; cfg_to = 32'h0; cfg_limit = 8'd0;
        cfg_we = 1'b1;
        retire = 1'b1; pc = 32'h1000; pc_next = 32'h1004;
        step();
        cfg_we = 1'b0;
        retire = 1'b0;
        chk("cfgwin_count0", 32'(cnt(0)), 32'd0);
        chk("cfgwin_hit0", 32'(hit[0]), 32'h0);
        ret(32'h1000, 32'h1004, 1'b0);
        chk("after_cfg_count0", 32'(cnt(0)), 32'd1);
        chk("after_cfg_hit", 32'(hit), 32'h1);

        // Mid-run asynchronous reset with a pending halt
        cfg(2'd2, 1'b1, 1'b0, 32'h1008, 32'h0, 8'd1);
        ret(32'h1008, 32'h100C, 1'b0);
        chk("prerst_halt_req", 32'(halt_req), 32'h1);
        chk("prerst_halt_idx", 32'(halt_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 32'h0);
        chk("arst_hit", 32'(hit), 32'h0);
        chk("arst_halt_req", 32'(halt_req), 32'h0);
        chk("arst_halt_idx", 32'(halt_idx), 32'h0);
        step();
        rst_n = 1'b1;
        loop_iter();
        chk("postrst_count", count, 32'h0);
        chk("postrst_hit", 32'(hit), 32'h0);
        chk("postrst_halt_req", 32'(halt_req), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
